pacman_input_ctrl: RTL and testbench
====================================

PACMAN_INPUT_CTRL -- requirements
Module: pacman_input_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL have parameter DEB_FRAMES, default 3: the number of consecutive start_of_frame samples a key must hold before its debounced level changes.
REQ-003 Ports, in this order:
- clk  in  1  system clock.
- reset  in  1  async active-high reset.
- start_of_frame  in  1  one-cycle pulse per frame, 30Hz.
- key_right/key_left/key_up/key_down  in  1 each  raw asynchronous keys, active-high.
- key_start  in  1  raw asynchronous start key, active-high.
- is_alive  in  1  pacman alive level.
- lost_life  in  1  one-cycle pulse at the end of the death sequence.
- req_dir  out  2  requested direction, encoded with the `RIGHT/`LEFT/`UP/`DOWN macros.
- game_started  out  1  level; high once play has begun.
- dir_press  out  1  one-cycle pulse when req_dir takes a new press.

Function
REQ-004 Each of the 5 raw keys SHALL pass through a 2-flop synchronizer; the synchronized value is sampled only on start_of_frame.
REQ-005 Debounce: a per-key counter counts consecutive samples that differ from the debounced level.
- Counter clears on any sample equal to the debounced level.
- When the count reaches DEB_FRAMES, the debounced level toggles and the counter clears.
- Counter width is $clog2(DEB_FRAMES+1).
- Counter saturates and never wraps.
REQ-006 Press event: the debounced level goes 0->1, registered as a one-cycle pulse in the cycle after the debounced update.
REQ-007 FSM states and transitions:
- IDLE_ST -> RUN_ST on a key_start press event.
- RUN_ST -> DEAD_ST when is_alive==0.
- DEAD_ST -> RUN_ST on lost_life.
- Reset enters IDLE_ST.
REQ-008 game_started SHALL be 0 in IDLE_ST and 1 in RUN_ST and DEAD_ST.
REQ-009 In RUN_ST, a direction press event SHALL load req_dir on the next clk edge and assert dir_press for that same single cycle.
REQ-010 req_dir is sticky: it holds its value until the next direction press event. Key release does not change it.
REQ-011 Simultaneous direction press events in the same cycle SHALL resolve by fixed priority UP > DOWN > LEFT > RIGHT; exactly one dir_press pulse is issued.
REQ-012 In IDLE_ST and DEAD_ST:
- direction press events are ignored;
- dir_press stays 0;
- req_dir is forced to `LEFT.
REQ-013 On lost_life in DEAD_ST, req_dir SHALL be `LEFT in the cycle RUN_ST is entered. A press in that same cycle is ignored.
REQ-014 A key held through a state change SHALL NOT generate a press; only a new 0->1 debounced transition counts.
REQ-015 is_alive==0 in IDLE_ST SHALL be ignored.
REQ-016 lost_life outside DEAD_ST SHALL be ignored.
REQ-017 The key_start press is ignored in RUN_ST and DEAD_ST.

Reset
REQ-018 On reset assertion, asynchronously:
- req_dir=`LEFT, game_started=0, dir_press=0;
- FSM=IDLE_ST;
- synchronizers, debounced levels and counters = 0.
REQ-019 Reset asserted mid-debounce or mid-game SHALL discard all progress. No press event may be generated from pre-reset key history.

Structure
REQ-020 DEB_FRAMES default and the state enum (IDLE_ST, RUN_ST, DEAD_ST) SHALL live in a shared package, input_pkg. Direction encodings come from include/constants.vh.
REQ-021 A sub-module key_debounce SHALL contain one key's synchronizer, counter, debounced level and press pulse. It is instantiated 5 times.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Start: reset, then key_start held 5 frames -> game_started=1 exactly one cycle after the 3rd sampled frame; req_dir=`LEFT.
- Glitch rejection: in RUN_ST, key_up high for 2 frames then low -> no dir_press, req_dir stays `LEFT. Held for 3 frames -> req_dir=`UP and one dir_press pulse.
- Priority: key_down and key_right rise in the same cycle and are held 3 frames -> req_dir=`DOWN, one dir_press.
- Death: is_alive=0 -> presses ignored, req_dir=`LEFT, game_started stays 1. lost_life pulse -> RUN_ST; a new key_right press -> req_dir=`RIGHT.
- Held key: key_up held across lost_life -> no press after returning to RUN_ST until released and pressed again.
- Reset mid-game: reset pulse in RUN_ST with req_dir=`UP -> req_dir=`LEFT, game_started=0 immediately (asynchronous).

Source files
------------

// File: rtl/input_pkg.sv
// Shared definitions for the Pac-Man input controller: direction encodings,
// debounce depth, key indices and the game-phase state enum.
`ifndef RIGHT
`define RIGHT 2'd0
`endif
`ifndef LEFT
`define LEFT 2'd1
`endif
`ifndef UP
`define UP 2'd2
`endif
`ifndef DOWN
`define DOWN 2'd3
`endif

package input_pkg;

    localparam int DEB_FRAMES_DEF = 3;
    localparam int NUM_KEYS       = 5;

    // Bit positions inside the packed raw-key / press-event vectors
    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_START = 4;

    typedef enum logic [1:0] {
        IDLE_ST = 2'd0,
        RUN_ST  = 2'd1,
        DEAD_ST = 2'd2
    } state_t;

    // Fixed priority UP > DOWN > LEFT > RIGHT; caller guarantees at least one bit set
    function automatic logic [1:0] pick_dir(input logic [3:0] presses);
        logic [1:0] dir;
        dir = `RIGHT;
        if (presses[KEY_UP])        dir = `UP;
        else if (presses[KEY_DOWN]) dir = `DOWN;
        else if (presses[KEY_LEFT]) dir = `LEFT;
        return dir;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, frame-sampled saturating debounce counter,
// debounced level and a one-cycle rising-edge press pulse.
module key_debounce #(
    parameter int DEB_FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sof,
    input  logic i_key,
    output logic o_press
);

    localparam int            CW      = $clog2(DEB_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_FRAMES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    logic          w_diff;
    logic          w_hit;
    logic [CW-1:0] w_cnt_inc;

    assign w_diff    = r_sync2 ^ r_level;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    assign w_hit     = i_sof && w_diff && (w_cnt_inc == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            // Pulse only on a 0->1 toggle of the debounced level
            r_press <= w_hit && !r_level;
            if (i_sof) begin
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_hit) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/pacman_input_ctrl.sv
// Pac-Man input controller: debounces the five keys and turns direction
// presses into a sticky requested direction gated by the game phase.
module pacman_input_ctrl
    import input_pkg::*;
#(
    parameter int DEB_FRAMES = DEB_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_of_frame,
    input  logic       key_right,
    input  logic       key_left,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_start,
    input  logic       is_alive,
    input  logic       lost_life,
    output logic [1:0] req_dir,
    output logic       game_started,
    output logic       dir_press
);

    logic [NUM_KEYS-1:0] w_raw;
    logic [NUM_KEYS-1:0] w_press;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_req_dir;
    logic [1:0] w_dir_nxt;
    logic       r_dir_press;
    logic       w_press_nxt;

    assign w_raw = {key_start, key_down, key_up, key_left, key_right};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEB_FRAMES(DEB_FRAMES)
        ) u_key_debounce (
            .clk    (clk),
            .reset  (reset),
            .i_sof  (start_of_frame),
            .i_key  (w_raw[g]),
            .o_press(w_press[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE_ST;
            r_req_dir   <= `LEFT;
            r_dir_press <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_dir   <= w_dir_nxt;
            r_dir_press <= w_press_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_req_dir;
        w_press_nxt = 1'b0;
        case (r_state)
            IDLE_ST: if (w_press[KEY_START]) w_state_nxt = RUN_ST;
            RUN_ST:  if (!is_alive)          w_state_nxt = DEAD_ST;
            DEAD_ST: if (lost_life)          w_state_nxt = RUN_ST;
            default: w_state_nxt = IDLE_ST;
        endcase
        // Presses only count while staying in RUN_ST; any other phase or
        // entry into RUN_ST parks the direction at LEFT.
        if (r_state == RUN_ST && w_state_nxt == RUN_ST) begin
            if (|w_press[KEY_DOWN:KEY_RIGHT]) begin
                w_dir_nxt   = pick_dir(w_press[KEY_DOWN:KEY_RIGHT]);
                w_press_nxt = 1'b1;
            end
        end else begin
            w_dir_nxt = `LEFT;
        end
    end

    assign req_dir      = r_req_dir;
    assign dir_press    = r_dir_press;
    assign game_started = (r_state != IDLE_ST);

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Directed bench for pacman_input_ctrl: frame-paced key stimulus with
// hand-computed expectations for phase, requested direction and press pulses.
module tb_pacman_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_of_frame = 1'b0;
    logic       key_right = 1'b0;
    logic       key_left = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_start = 1'b0;
    logic       is_alive = 1'b0;
    logic       lost_life = 1'b0;
    logic [1:0] req_dir;
    logic       game_started;
    logic       dir_press;

    int n_chk = 0;
    int n_err = 0;
    int dp_cnt = 0;
    int dp_base = 0;

    pacman_input_ctrl #(.DEB_FRAMES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_of_frame(start_of_frame),
        .key_right     (key_right),
        .key_left      (key_left),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_start     (key_start),
        .is_alive      (is_alive),
        .lost_life     (lost_life),
        .req_dir       (req_dir),
        .game_started  (game_started),
        .dir_press     (dir_press)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dir_press) dp_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Seven idle cycles, then one start_of_frame pulse; returns at the
    // negedge right after the edge that sampled the frame.
    task automatic frames(input int n);
        repeat (n) begin
            tick(7);
            start_of_frame = 1'b1;
            @(negedge clk);
            start_of_frame = 1'b0;
        end
    endtask

    task automatic pulse_lost_life();
        lost_life = 1'b1;
        @(negedge clk);
        lost_life = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_req_dir", req_dir, `LEFT);
        check("rst_started", game_started, 1'b0);
        check("rst_dir_press", dir_press, 1'b0);
        reset = 1'b0;

        // is_alive low while idle has no effect
        tick(5);
        check("idle_dead_ignored", game_started, 1'b0);
        is_alive = 1'b1;

        // Direction press while idle is ignored
        dp_base = dp_cnt;
        key_right = 1'b1;
        frames(3);
        tick(2);
        check("idle_press_pulses", dp_cnt - dp_base, 0);
        check("idle_press_dir", req_dir, `LEFT);
        key_right = 1'b0;
        frames(3);

        // Start progress before a reset is discarded
        key_start = 1'b1;
        frames(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        frames(1);
        tick(2);
        check("post_rst_1frame", game_started, 1'b0);
        frames(1);
        check("post_rst_2frame", game_started, 1'b0);
        frames(1);
        check("start_same_cycle", game_started, 1'b0);
        tick(1);
        check("start_next_cycle", game_started, 1'b1);
        check("start_dir", req_dir, `LEFT);
        frames(2);
        key_start = 1'b0;
        frames(3);

        // Glitch rejection then a real UP press
        dp_base = dp_cnt;
        key_up = 1'b1;
        frames(2);
        key_up = 1'b0;
        frames(2);
        tick(2);
        check("glitch_pulses", dp_cnt - dp_base, 0);
        check("glitch_dir", req_dir, `LEFT);
        key_up = 1'b1;
        frames(3);
        tick(3);
        check("up_dir", req_dir, `UP);
        check("up_pulses", dp_cnt - dp_base, 1);
        key_up = 1'b0;
        frames(3);

        pulse_lost_life();
        tick(2);
        check("run_lost_life_dir", req_dir, `UP);
        check("run_lost_life_started", game_started, 1'b1);

        // Priority cases
        dp_base = dp_cnt;
        key_down = 1'b1;
        key_right = 1'b1;
        frames(3);
        tick(3);
        check("prio_dr_dir", req_dir, `DOWN);
        check("prio_dr_pulses", dp_cnt - dp_base, 1);
        key_down = 1'b0;
        key_right = 1'b0;
        frames(3);

        dp_base = dp_cnt;
        key_left = 1'b1;
        key_right = 1'b1;
        frames(3);
        tick(3);
        check("prio_lr_dir", req_dir, `LEFT);
        check("prio_lr_pulses", dp_cnt - dp_base, 1);
        key_left = 1'b0;
        key_right = 1'b0;
        frames(3);

        dp_base = dp_cnt;
        {key_up, key_down, key_left, key_right} = 4'hF;
        frames(3);
        tick(3);
        check("prio_all_dir", req_dir, `UP);
        check("prio_all_pulses", dp_cnt - dp_base, 1);
        {key_up, key_down, key_left, key_right} = 4'h0;
        frames(3);

        // Death: presses ignored, direction parked at LEFT
        is_alive = 1'b0;
        tick(2);
        check("dead_started", game_started, 1'b1);
        check("dead_dir", req_dir, `LEFT);
        dp_base = dp_cnt;
        key_down = 1'b1;
        frames(3);
        tick(3);
        check("dead_press_pulses", dp_cnt - dp_base, 0);
        check("dead_press_dir", req_dir, `LEFT);
        key_down = 1'b0;
        frames(3);
        is_alive = 1'b1;
        tick(2);
        check("dead_alive_dir", req_dir, `LEFT);
        pulse_lost_life();
        check("revive_dir", req_dir, `LEFT);
        check("revive_started", game_started, 1'b1);
        dp_base = dp_cnt;
        key_right = 1'b1;
        frames(3);
        tick(3);
        check("revive_right_dir", req_dir, `RIGHT);
        check("revive_right_pulses", dp_cnt - dp_base, 1);
        key_right = 1'b0;
        frames(3);

        // Key held across death and revival does not re-press
        key_up = 1'b1;
        frames(3);
        tick(3);
        check("held_up_dir", req_dir, `UP);
        is_alive = 1'b0;
        tick(2);
        check("held_dead_dir", req_dir, `LEFT);
        is_alive = 1'b1;
        pulse_lost_life();
        dp_base = dp_cnt;
        frames(4);
        tick(3);
        check("held_pulses", dp_cnt - dp_base, 0);
        check("held_dir", req_dir, `LEFT);
        key_up = 1'b0;
        frames(3);
        key_up = 1'b1;
        frames(3);
        tick(3);
        check("repress_dir", req_dir, `UP);
        check("repress_pulses", dp_cnt - dp_base, 1);

        // Asynchronous reset mid-game
        #2;
        reset = 1'b1;
        key_up = 1'b0;
        #1;
        check("async_rst_dir", req_dir, `LEFT);
        check("async_rst_started", game_started, 1'b0);
        check("async_rst_dir_press", dir_press, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        frames(3);
        check("after_rst_idle", game_started, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
